la_capture_mux: RTL and testbench

LA_CAPTURE_MUX -- requirements
Module: la_capture_mux

---
 rtl/la_pkg.sv | 17 +
 rtl/la_trig_cmp.sv | 14 +
 rtl/la_capture_mux.sv | 175 +++++++++++++++++
 tb/tb_la_capture_mux.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/la_pkg.sv
// la_pkg: shared FSM encoding and default constants
// for the logic-analyzer capture mux.
package la_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SWITCH = 2'd1,
    ARMED  = 2'd2,
    FROZEN = 2'd3
  } la_state_e;

  localparam int LA_NUM_CH     = 13;
  localparam int LA_DATA_W     = 128;
  localparam int LA_SETTLE_CYC = 2;
  localparam int LA_CNT_W      = 4;

endpackage

// File: rtl/la_trig_cmp.sv
// la_trig_cmp: masked equality compare, combinational.
// dat/mask/val: DATA_W words; hit: (dat & mask) == (val & mask).
module la_trig_cmp #(
  parameter int DATA_W = 128
) (
  input  logic [DATA_W-1:0] dat,
  input  logic [DATA_W-1:0] mask,
  input  logic [DATA_W-1:0] val,
  output logic              hit
);

  assign hit = ((dat ^ val) & mask) == '0;

endmodule

// File: rtl/la_capture_mux.sv
// la_capture_mux: registered channel mux with selection
// blanking and optional freeze trigger (LA_CAPTURE_MUX_TRIG_EN).
// Ports: clk, nrst (async low); la_sel/sel_load pick a channel;
// la_dat packs NUM_CH words (channel i at [i*DATA_W +: DATA_W]);
// trig_arm/trig_mask/trig_val/frz_release drive the freeze;
// muxxed_la_dat/dat_valid data out, sel_err, cur_sel, state_o.
module la_capture_mux
  import la_pkg::*;
#(
  parameter  int NUM_CH     = LA_NUM_CH,
  parameter  int DATA_W     = LA_DATA_W,
  parameter  int SETTLE_CYC = LA_SETTLE_CYC,
  localparam int SEL_W      = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic [SEL_W-1:0]         la_sel,
  input  logic                     sel_load,
  input  logic [NUM_CH*DATA_W-1:0] la_dat,
  input  logic                     trig_arm,
  input  logic [DATA_W-1:0]        trig_mask,
  input  logic [DATA_W-1:0]        trig_val,
  input  logic                     frz_release,
  output logic [DATA_W-1:0]        muxxed_la_dat,
  output logic                     dat_valid,
  output logic                     sel_err,
  output logic [SEL_W-1:0]         cur_sel,
  output logic [1:0]               state_o
);

  localparam logic [SEL_W-1:0] MAX_SEL =
    SEL_W'(NUM_CH - 1);
  localparam logic [LA_CNT_W-1:0] SETTLE =
    LA_CNT_W'(SETTLE_CYC);

  la_state_e            state, state_n;
  logic [LA_CNT_W-1:0]  cnt, cnt_n;
  logic [SEL_W-1:0]     sel_n;
  logic [SEL_W-1:0]     sel_sat;
  logic                 sel_oor;
  logic [DATA_W-1:0]    dat_n;
  logic                 valid_n;
  logic                 err_n;
  logic [DATA_W-1:0]    ch [NUM_CH];
  logic [DATA_W-1:0]    live;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      ch[i] = la_dat[i*DATA_W +: DATA_W];
    end
  end

  assign live    = ch[cur_sel];
  assign sel_oor = la_sel > MAX_SEL;
  assign sel_sat = sel_oor ? MAX_SEL : la_sel;

`ifdef LA_CAPTURE_MUX_TRIG_EN
  logic hit;

  la_trig_cmp #(
    .DATA_W (DATA_W)
  ) u_cmp (
    .dat  (live),
    .mask (trig_mask),
    .val  (trig_val),
    .hit  (hit)
  );
`else
  logic unused_trig;
  assign unused_trig =
    ^{trig_arm, trig_mask, trig_val, frz_release};
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state         <= RUN;
      cnt           <= '0;
      cur_sel       <= '0;
      muxxed_la_dat <= '0;
      dat_valid     <= 1'b0;
      sel_err       <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      cur_sel       <= sel_n;
      muxxed_la_dat <= dat_n;
      dat_valid     <= valid_n;
      sel_err       <= err_n;
    end
  end

  // A selection load always wins: it blanks the
  // output even when a trigger hits the same cycle.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sel_n   = sel_load ? sel_sat : cur_sel;
    unique case (state)
      RUN: begin
        if (sel_load) begin
          state_n = SWITCH;
          cnt_n   = SETTLE;
        end
`ifdef LA_CAPTURE_MUX_TRIG_EN
        else if (trig_arm) begin
          state_n = ARMED;
        end
`endif
      end
      SWITCH: begin
        if (sel_load) begin
          cnt_n = SETTLE;
        end else if (cnt <= 1) begin
          state_n = RUN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
`ifdef LA_CAPTURE_MUX_TRIG_EN
      ARMED: begin
        if (sel_load) begin
          state_n = SWITCH;
          cnt_n   = SETTLE;
        end else if (hit) begin
          state_n = FROZEN;
        end
      end
      FROZEN: begin
        if (frz_release) begin
          state_n = SWITCH;
          cnt_n   = SETTLE;
        end
      end
`endif
      default: begin
        state_n = RUN;
        cnt_n   = '0;
      end
    endcase
  end

  // Output words are computed for the state being
  // entered so they line up with it after the edge.
  always_comb begin
    dat_n   = '0;
    valid_n = 1'b0;
    err_n   = sel_load & sel_oor;
    unique case (state_n)
      RUN: begin
        dat_n   = live;
        valid_n = 1'b1;
      end
`ifdef LA_CAPTURE_MUX_TRIG_EN
      ARMED: begin
        dat_n   = live;
        valid_n = 1'b1;
      end
      FROZEN: begin
        // On entry capture the hit word, then hold it.
        dat_n   = (state == FROZEN) ? muxxed_la_dat
                                    : live;
        valid_n = 1'b1;
      end
`endif
      default: begin
        dat_n   = '0;
        valid_n = 1'b0;
      end
    endcase
  end

  assign state_o = state;

endmodule

// File: tb/tb_la_capture_mux.sv
// tb_la_capture_mux: vector table plus hand sequences,
// expectations queued at drive time and checked after the edge.
module tb_la_capture_mux;
  import la_pkg::*;

  localparam int NC = 13;
  localparam int DW = 128;

  logic           clk = 1'b0;
  logic           nrst = 1'b0;
  logic [3:0]     la_sel = '0;
  logic           sel_load = 1'b0;
  logic           trig_arm = 1'b0;
  logic           frz_release = 1'b0;
  logic [DW-1:0]  trig_mask = '0;
  logic [DW-1:0]  trig_val = '0;
  logic [DW-1:0]  chan [NC];
  logic [NC*DW-1:0] la_dat;
  logic [DW-1:0]  muxxed_la_dat;
  logic           dat_valid;
  logic           sel_err;
  logic [3:0]     cur_sel;
  logic [1:0]     state_o;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NC; g++) begin : g_pack
    assign la_dat[g*DW +: DW] = chan[g];
  end

  la_capture_mux u_dut (
    .clk           (clk),
    .nrst          (nrst),
    .la_sel        (la_sel),
    .sel_load      (sel_load),
    .la_dat        (la_dat),
    .trig_arm      (trig_arm),
    .trig_mask     (trig_mask),
    .trig_val      (trig_val),
    .frz_release   (frz_release),
    .muxxed_la_dat (muxxed_la_dat),
    .dat_valid     (dat_valid),
    .sel_err       (sel_err),
    .cur_sel       (cur_sel),
    .state_o       (state_o)
  );

  typedef struct {
    logic          valid;
    logic [3:0]    sel;
    logic [DW-1:0] data;
    logic          err;
    logic [1:0]    st;
  } exp_t;

  typedef struct {
    logic       ld;
    logic [3:0] sel;
    logic       ev;
    logic [3:0] es;
    int         ech;
    logic       ee;
    logic [1:0] est;
  } vec_t;

  exp_t sbq[$];
  vec_t tbl[22];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [DW-1:0] pat(int i);
    logic [7:0] b;
    b = (i == 0) ? 8'hA5 : 8'(17 * i);
    return {16{b}};
  endfunction

  task automatic chk(string name, logic [DW-1:0] act,
                     logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic step(string tag, logic ld, logic [3:0] sel,
                      logic arm, logic rel, logic ev,
                      logic [3:0] es, logic [DW-1:0] ed,
                      logic ee, logic [1:0] est);
    exp_t e;
    sel_load    = ld;
    la_sel      = sel;
    trig_arm    = arm;
    frz_release = rel;
    sbq.push_back('{valid: ev, sel: es, data: ed,
                    err: ee, st: est});
    @(posedge clk);
    #1;
    sel_load    = 1'b0;
    trig_arm    = 1'b0;
    frz_release = 1'b0;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      e = sbq.pop_front();
      chk({tag, ".valid"}, DW'(dat_valid), DW'(e.valid));
      chk({tag, ".sel"},   DW'(cur_sel),   DW'(e.sel));
      chk({tag, ".data"},  muxxed_la_dat,  e.data);
      chk({tag, ".err"},   DW'(sel_err),   DW'(e.err));
      chk({tag, ".state"}, DW'(state_o),   DW'(e.st));
    end
    @(negedge clk);
  endtask

  task automatic chk_reset(string tag);
    chk({tag, ".valid"}, DW'(dat_valid), '0);
    chk({tag, ".sel"},   DW'(cur_sel),   '0);
    chk({tag, ".data"},  muxxed_la_dat,  '0);
    chk({tag, ".err"},   DW'(sel_err),   '0);
    chk({tag, ".state"}, DW'(state_o),   DW'(RUN));
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] w;
    w = 128'h0123456789abcdef0123456789abcd3c;
    for (int i = 0; i < NC; i++) chan[i] = pat(i);

    tbl[0]  = '{0, 0,  1, 0,  0,  0, RUN};
    tbl[1]  = '{0, 0,  1, 0,  0,  0, RUN};
    tbl[2]  = '{1, 5,  0, 5,  -1, 0, SWITCH};
    tbl[3]  = '{0, 0,  0, 5,  -1, 0, SWITCH};
    tbl[4]  = '{0, 0,  1, 5,  5,  0, RUN};
    tbl[5]  = '{0, 0,  1, 5,  5,  0, RUN};
    tbl[6]  = '{1, 15, 0, 12, -1, 1, SWITCH};
    tbl[7]  = '{0, 0,  0, 12, -1, 0, SWITCH};
    tbl[8]  = '{0, 0,  1, 12, 12, 0, RUN};
    tbl[9]  = '{1, 3,  0, 3,  -1, 0, SWITCH};
    tbl[10] = '{1, 7,  0, 7,  -1, 0, SWITCH};
    tbl[11] = '{0, 0,  0, 7,  -1, 0, SWITCH};
    tbl[12] = '{0, 0,  1, 7,  7,  0, RUN};
    tbl[13] = '{1, 7,  0, 7,  -1, 0, SWITCH};
    tbl[14] = '{0, 0,  0, 7,  -1, 0, SWITCH};
    tbl[15] = '{0, 0,  1, 7,  7,  0, RUN};
    tbl[16] = '{1, 12, 0, 12, -1, 0, SWITCH};
    tbl[17] = '{0, 0,  0, 12, -1, 0, SWITCH};
    tbl[18] = '{0, 0,  1, 12, 12, 0, RUN};
    tbl[19] = '{1, 13, 0, 12, -1, 1, SWITCH};
    tbl[20] = '{0, 0,  0, 12, -1, 0, SWITCH};
    tbl[21] = '{0, 0,  1, 12, 12, 0, RUN};

    repeat (2) @(posedge clk);
    #1;
    chk_reset("rst0");
    @(negedge clk);
    nrst = 1'b1;

    for (int i = 0; i < 22; i++) begin
      step($sformatf("v%0d", i), tbl[i].ld, tbl[i].sel,
           1'b0, 1'b0, tbl[i].ev, tbl[i].es,
           (tbl[i].ech < 0) ? '0 : chan[tbl[i].ech],
           tbl[i].ee, tbl[i].est);
    end

    for (int k = 0; k < 4; k++) begin
      chan[12] = {$urandom, $urandom, $urandom, $urandom};
      step($sformatf("lat%0d", k), 0, 0, 0, 0,
           1, 12, chan[12], 0, RUN);
    end
    chan[12] = pat(12);

    trig_mask = 128'hFF;
    trig_val  = 128'h3C;

`ifdef LA_CAPTURE_MUX_TRIG_EN
    step("a1", 0, 0, 1, 0, 1, 12, chan[12], 0, ARMED);
    step("a2", 0, 0, 0, 0, 1, 12, chan[12], 0, ARMED);
    chan[12] = w;
    step("a3", 0, 0, 0, 0, 1, 12, w, 0, FROZEN);
    chan[12] = pat(12);
    step("f1", 0, 0, 0, 0, 1, 12, w, 0, FROZEN);
    step("f2", 1, 4, 0, 0, 1, 4, w, 0, FROZEN);
    step("f3", 0, 0, 1, 0, 1, 4, w, 0, FROZEN);
    step("f4", 0, 0, 0, 1, 0, 4, '0, 0, SWITCH);
    step("f5", 0, 0, 0, 0, 0, 4, '0, 0, SWITCH);
    step("f6", 0, 0, 0, 0, 1, 4, chan[4], 0, RUN);

    step("p1", 0, 0, 1, 0, 1, 4, chan[4], 0, ARMED);
    chan[4] = w;
    step("p2", 1, 6, 0, 0, 0, 6, '0, 0, SWITCH);
    chan[4] = pat(4);
    step("p3", 0, 0, 0, 0, 0, 6, '0, 0, SWITCH);
    step("p4", 0, 0, 0, 0, 1, 6, chan[6], 0, RUN);

    step("s1", 0, 0, 1, 0, 1, 6, chan[6], 0, ARMED);
    chan[6] = w;
    step("s2", 0, 0, 0, 0, 1, 6, w, 0, FROZEN);
    chan[6] = pat(6);
    step("s3", 1, 15, 0, 1, 0, 12, '0, 1, SWITCH);
    step("s4", 0, 0, 0, 0, 0, 12, '0, 0, SWITCH);
    step("s5", 0, 0, 0, 0, 1, 12, chan[12], 0, RUN);

    step("r1", 1, 9, 1, 0, 0, 9, '0, 0, SWITCH);
    step("r2", 0, 0, 0, 0, 0, 9, '0, 0, SWITCH);
    step("r3", 0, 0, 0, 0, 1, 9, chan[9], 0, RUN);
    step("r4", 0, 0, 1, 0, 1, 9, chan[9], 0, ARMED);
    chan[9] = w;
    step("r5", 0, 0, 0, 0, 1, 9, w, 0, FROZEN);
    chan[9] = pat(9);
    nrst = 1'b0;
    #1;
    chk_reset("rfrz");
    @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
    step("r6", 0, 0, 0, 0, 1, 0, chan[0], 0, RUN);
`else
    chan[12] = w;
    step("n1", 0, 0, 1, 0, 1, 12, w, 0, RUN);
    step("n2", 0, 0, 0, 0, 1, 12, w, 0, RUN);
    step("n3", 0, 0, 0, 1, 1, 12, w, 0, RUN);
    chan[12] = pat(12);
    step("n4", 0, 0, 1, 0, 1, 12, chan[12], 0, RUN);
`endif

    step("w1", 1, 5, 0, 0, 0, 5, '0, 0, SWITCH);
    nrst = 1'b0;
    #1;
    chk_reset("rsw");
    @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
    step("w2", 0, 0, 0, 0, 1, 0, chan[0], 0, RUN);
    step("w3", 0, 0, 0, 0, 1, 0, chan[0], 0, RUN);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
